piezo_note_sequencer: RTL and testbench
=======================================

Name: piezo_note_sequencer

Overview:
- Sequences the piezo tone generator in the vending machine.
- Collects one-cycle melody requests from the coin and dispense logic and arbitrates between them.
- Steps the tone generator through the four notes of the granted melody by driving its `note_state` and `note_played` inputs, then inserts a silent gap.
- Signals completion with `done`; requests arriving while a melody plays are queued, not dropped.

Parameters:
- NOTE_TICKS, 24'd5_000_000, clk cycles each note index is held (must be ≥1).
- GAP_TICKS, 24'd2_500_000, clk cycles of silence after note 4 (0 = no gap state).
- CNT_W, 24, width of the duration counter; both tick parameters must fit in it.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- req  input  6  one-cycle request pulses: [0]=100w, [1]=500w, [2]=1000w, [3]=prod1, [4]=prod2, [5]=prod3
- abort  input  1  synchronous cancel of current melody and all pending requests
- mute  input  1  forces note_played to 0 while sequencing continues
- note_state  output  3  melody code to tone generator (1..6, 0 = none)
- note_played  output  3  note index to tone generator (1..4, 0 = silent)
- busy  output  1  high in PLAY or GAP
- done  output  1  one-cycle pulse when a melody completes normally
- pending  output  6  queued, not-yet-granted requests

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; note_state=0, note_played=0, busy=0, done=0, pending=0; counter and note index cleared.
- Request latch:
  - Each clk edge: pending |= req.
  - Clearing the granted bit happens at grant; if the same bit's req is high in the grant cycle, set wins and the bit stays pending.
- Arbitration:
  - Fixed priority, lowest bit index wins (100w highest, prod3 lowest).
  - Evaluated only in IDLE, on registered pending. A request latched at edge k can be granted at edge k+1 at the earliest.
- States IDLE, PLAY, GAP; all outputs registered.
- IDLE:
  - note_state=0, note_played=0, busy=0.
  - If pending≠0 and abort=0: at the next edge grant winner w, clear pending[w], set note_state=w+1, note_index=1, cnt=0, go to PLAY.
- PLAY:
  - busy=1; note_played = mute ? 0 : note_index.
  - cnt increments each cycle; at cnt==NOTE_TICKS-1: cnt←0, note_index++.
  - After index 4 expires: go to GAP if GAP_TICKS>0, else finish.
  - Each index is visible for exactly NOTE_TICKS cycles; melody length is 4·NOTE_TICKS cycles.
- GAP:
  - busy=1, note_played=0, note_state=0.
  - Lasts GAP_TICKS cycles, then finish.
- Finish:
  - Go to IDLE; done=1 for exactly the first IDLE cycle.
  - Next pending melody is granted at the edge ending that cycle, so there is one idle cycle between melodies.
- abort:
  - In any state, at the next edge: pending←0, state←IDLE, outputs←0, done stays 0.
  - req arriving in the same cycle as abort is discarded.
- mute affects only note_played. Timing, done, and pending are unchanged.
- Re-request of the melody currently playing re-queues it; it plays again afterwards.
- Simultaneous multiple req bits are all latched and served in priority order, one per melody.
- Reset mid-melody: immediate silence, all state lost, no done.

Test Plan:
- Single request: NOTE_TICKS=4, GAP_TICKS=2, pulse req=6'b000001 at edge 0.
  - note_state=1 from edge 1.
  - note_played=1,2,3,4, each for 4 cycles (edges 1–16).
  - note_played=0 for edges 17–18.
  - done=1 at edge 19 only; busy high for edges 1–18.
- Priority and queueing: req=6'b101000 in one cycle.
  - prod1 (note_state=4) plays first; pending=6'b100000 during it.
  - After done plus one idle cycle, note_state=6 plays; then pending=0.
- Request during play: req[1] pulsed mid prod2 melody.
  - pending[1]=1 until prod2's done cycle.
  - Then note_state=2 is granted; current melody is not interrupted.
- Abort: abort pulsed during note 3 of 1000w, with pending[4]=1.
  - Next edge: note_played=0, note_state=0, busy=0, pending=0, no done pulse.
- Mute: mute=1 throughout a 500w melody.
  - note_played stays 0; note_state=2 for 16 cycles; done fires at the same edge as the unmuted case.
- Async reset: rst low mid-PLAY, between clock edges.
  - All outputs go 0 immediately.
  - After release, a new req[0] pulse produces a full normal sequence.
- GAP_TICKS=0: done follows the final note directly, at edge 17 for NOTE_TICKS=4.

Source files
------------

// File: rtl/piezo_note_sequencer.sv
// Melody sequencer for the vending machine piezo: queues request pulses, grants them
// by fixed priority and steps the tone generator through four notes plus a silent gap.
module piezo_note_sequencer #(
   parameter int               CNT_W      = 24,
   parameter logic [CNT_W-1:0] NOTE_TICKS = 24'd5_000_000,
   parameter logic [CNT_W-1:0] GAP_TICKS  = 24'd2_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] req,
   input  logic       abort,
   input  logic       mute,
   output logic [2:0] note_state,
   output logic [2:0] note_played,
   output logic       busy,
   output logic       done,
   output logic [5:0] pending
);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   localparam logic [CNT_W-1:0] NOTE_LAST = NOTE_TICKS - CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_LAST  = GAP_TICKS - CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       note_index;
   logic [2:0]       win_idx;
   logic [5:0]       win_mask;

   // Lowest set bit of the registered queue wins; scanning downward lets it overwrite.
   always_comb begin
      win_idx  = 3'd0;
      win_mask = 6'd0;
      for (int i = 5; i >= 0; i--) begin
         if (pending[i]) begin
            win_idx  = 3'(i);
            win_mask = 6'd1 << i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         note_index  <= 3'd0;
         note_state  <= 3'd0;
         note_played <= 3'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pending     <= 6'd0;
      end else if (abort) begin
         state       <= IDLE;
         cnt         <= '0;
         note_index  <= 3'd0;
         note_state  <= 3'd0;
         note_played <= 3'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pending     <= 6'd0;
      end else begin
         done    <= 1'b0;
         pending <= pending | req;
         case (state)
            IDLE: begin
               if (pending != 6'd0) begin
                  // A request for the same melody in the grant cycle keeps its bit set.
                  pending     <= (pending & ~win_mask) | req;
                  note_state  <= win_idx + 3'd1;
                  note_index  <= 3'd1;
                  note_played <= mute ? 3'd0 : 3'd1;
                  cnt         <= '0;
                  busy        <= 1'b1;
                  state       <= PLAY;
               end
            end
            PLAY: begin
               if (cnt == NOTE_LAST) begin
                  cnt <= '0;
                  if (note_index == 3'd4) begin
                     note_played <= 3'd0;
                     note_state  <= 3'd0;
                     note_index  <= 3'd0;
                     if (GAP_TICKS != '0) begin
                        state <= GAP;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     note_index  <= note_index + 3'd1;
                     note_played <= mute ? 3'd0 : note_index + 3'd1;
                  end
               end else begin
                  cnt         <= cnt + CNT_W'(1);
                  note_played <= mute ? 3'd0 : note_index;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piezo_note_sequencer.sv
// Directed bench for piezo_note_sequencer with short note/gap durations; a second
// instance without a gap state checks the direct note-to-done transition.
module tb_piezo_note_sequencer;

   logic       clk;
   logic       rst;
   logic [5:0] req;
   logic       abort;
   logic       mute;
   logic [2:0] note_state, note_played, note_state0, note_played0;
   logic       busy, done, busy0, done0;
   logic [5:0] pending, pending0;

   int checks = 0;
   int errors = 0;

   piezo_note_sequencer #(.CNT_W(24), .NOTE_TICKS(24'd4), .GAP_TICKS(24'd2)) dut (
      .clk(clk), .rst(rst), .req(req), .abort(abort), .mute(mute),
      .note_state(note_state), .note_played(note_played),
      .busy(busy), .done(done), .pending(pending)
   );

   piezo_note_sequencer #(.CNT_W(24), .NOTE_TICKS(24'd4), .GAP_TICKS(24'd0)) dut0 (
      .clk(clk), .rst(rst), .req(req), .abort(abort), .mute(mute),
      .note_state(note_state0), .note_played(note_played0),
      .busy(busy0), .done(done0), .pending(pending0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [5:0] r, input logic a);
      req   = r;
      abort = a;
      tick(1);
      req   = 6'd0;
      abort = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst   = 1'b0;
      req   = 6'd0;
      abort = 1'b0;
      mute  = 1'b0;

      // Reset state
      tick(2);
      checkOutput("rst_note_state", 8'(note_state), 8'd0);
      checkOutput("rst_note_played", 8'(note_played), 8'd0);
      checkOutput("rst_busy", 8'(busy), 8'd0);
      checkOutput("rst_done", 8'(done), 8'd0);
      checkOutput("rst_pending", 8'(pending), 8'd0);
      rst = 1'b1;
      tick(2);

      // Single 100w request, edge 0
      $display("[TB] single request");
      applyStimulus(6'b000001, 1'b0);
      checkOutput("t1_e0_pending", 8'(pending), 8'h01);
      checkOutput("t1_e0_busy", 8'(busy), 8'd0);
      for (int e = 1; e <= 16; e++) begin
         tick(1);
         checkOutput("t1_note_state", 8'(note_state), 8'd1);
         checkOutput("t1_note_played", 8'(note_played), 8'((e - 1) / 4 + 1));
         checkOutput("t1_busy", 8'(busy), 8'd1);
         checkOutput("t1_done", 8'(done), 8'd0);
         checkOutput("t1_nogap_played", 8'(note_played0), 8'((e - 1) / 4 + 1));
      end
      checkOutput("t1_e16_pending", 8'(pending), 8'd0);
      tick(1);
      checkOutput("t1_e17_played", 8'(note_played), 8'd0);
      checkOutput("t1_e17_state", 8'(note_state), 8'd0);
      checkOutput("t1_e17_busy", 8'(busy), 8'd1);
      checkOutput("t1_e17_done", 8'(done), 8'd0);
      checkOutput("t1_nogap_e17_done", 8'(done0), 8'd1);
      checkOutput("t1_nogap_e17_busy", 8'(busy0), 8'd0);
      tick(1);
      checkOutput("t1_e18_busy", 8'(busy), 8'd1);
      checkOutput("t1_e18_done", 8'(done), 8'd0);
      checkOutput("t1_nogap_e18_done", 8'(done0), 8'd0);
      tick(1);
      checkOutput("t1_e19_done", 8'(done), 8'd1);
      checkOutput("t1_e19_busy", 8'(busy), 8'd0);
      tick(1);
      checkOutput("t1_e20_done", 8'(done), 8'd0);
      checkOutput("t1_e20_busy", 8'(busy), 8'd0);

      // Priority and queueing: prod1 + prod3 together
      $display("[TB] priority");
      applyStimulus(6'b101000, 1'b0);
      checkOutput("t2_e0_pending", 8'(pending), 8'h28);
      tick(1);
      checkOutput("t2_e1_state", 8'(note_state), 8'd4);
      checkOutput("t2_e1_pending", 8'(pending), 8'h20);
      tick(18);
      checkOutput("t2_e19_done", 8'(done), 8'd1);
      checkOutput("t2_e19_pending", 8'(pending), 8'h20);
      tick(1);
      checkOutput("t2_e20_state", 8'(note_state), 8'd6);
      checkOutput("t2_e20_played", 8'(note_played), 8'd1);
      checkOutput("t2_e20_pending", 8'(pending), 8'd0);
      tick(17);
      checkOutput("t2_e37_done", 8'(done), 8'd0);
      tick(1);
      checkOutput("t2_e38_done", 8'(done), 8'd1);
      tick(1);

      // Request during play of prod2
      $display("[TB] request during play");
      applyStimulus(6'b010000, 1'b0);
      tick(6);
      checkOutput("t3_e6_state", 8'(note_state), 8'd5);
      applyStimulus(6'b000010, 1'b0);
      checkOutput("t3_e7_pending", 8'(pending), 8'h02);
      checkOutput("t3_e7_state", 8'(note_state), 8'd5);
      checkOutput("t3_e7_played", 8'(note_played), 8'd2);
      tick(11);
      checkOutput("t3_e18_pending", 8'(pending), 8'h02);
      checkOutput("t3_e18_busy", 8'(busy), 8'd1);
      tick(1);
      checkOutput("t3_e19_done", 8'(done), 8'd1);
      checkOutput("t3_e19_pending", 8'(pending), 8'h02);
      tick(1);
      checkOutput("t3_e20_state", 8'(note_state), 8'd2);
      checkOutput("t3_e20_pending", 8'(pending), 8'd0);
      tick(18);
      checkOutput("t3_e38_done", 8'(done), 8'd1);
      tick(1);

      // Abort during note 3 of 1000w with prod2 queued; concurrent req[0] is discarded
      $display("[TB] abort");
      applyStimulus(6'b010100, 1'b0);
      tick(1);
      checkOutput("t4_e1_state", 8'(note_state), 8'd3);
      checkOutput("t4_e1_pending", 8'(pending), 8'h10);
      tick(8);
      checkOutput("t4_e9_played", 8'(note_played), 8'd3);
      applyStimulus(6'b000001, 1'b1);
      checkOutput("t4_e10_played", 8'(note_played), 8'd0);
      checkOutput("t4_e10_state", 8'(note_state), 8'd0);
      checkOutput("t4_e10_busy", 8'(busy), 8'd0);
      checkOutput("t4_e10_pending", 8'(pending), 8'd0);
      checkOutput("t4_e10_done", 8'(done), 8'd0);
      for (int e = 11; e <= 22; e++) begin
         tick(1);
         checkOutput("t4_after_busy", 8'(busy), 8'd0);
         checkOutput("t4_after_done", 8'(done), 8'd0);
      end

      // Mute throughout a 500w melody
      $display("[TB] mute");
      mute = 1'b1;
      applyStimulus(6'b000010, 1'b0);
      for (int e = 1; e <= 16; e++) begin
         tick(1);
         checkOutput("t5_state", 8'(note_state), 8'd2);
         checkOutput("t5_played", 8'(note_played), 8'd0);
      end
      tick(2);
      checkOutput("t5_e18_busy", 8'(busy), 8'd1);
      checkOutput("t5_e18_done", 8'(done), 8'd0);
      tick(1);
      checkOutput("t5_e19_done", 8'(done), 8'd1);
      mute = 1'b0;
      tick(1);

      // Asynchronous reset mid-PLAY
      $display("[TB] async reset");
      applyStimulus(6'b100001, 1'b0);
      tick(5);
      checkOutput("t6_e5_played", 8'(note_played), 8'd2);
      checkOutput("t6_e5_pending", 8'(pending), 8'h20);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("t6_rst_state", 8'(note_state), 8'd0);
      checkOutput("t6_rst_played", 8'(note_played), 8'd0);
      checkOutput("t6_rst_busy", 8'(busy), 8'd0);
      checkOutput("t6_rst_pending", 8'(pending), 8'd0);
      tick(2);
      rst = 1'b1;
      tick(1);
      applyStimulus(6'b000001, 1'b0);
      tick(1);
      checkOutput("t6_e1_state", 8'(note_state), 8'd1);
      checkOutput("t6_e1_played", 8'(note_played), 8'd1);
      tick(4);
      checkOutput("t6_e5_played_new", 8'(note_played), 8'd2);
      tick(12);
      checkOutput("t6_e17_played", 8'(note_played), 8'd0);
      checkOutput("t6_e17_busy", 8'(busy), 8'd1);
      tick(2);
      checkOutput("t6_e19_done", 8'(done), 8'd1);
      checkOutput("t6_e19_pending", 8'(pending), 8'd0);
      tick(1);
      checkOutput("t6_e20_done", 8'(done), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
